ahb_resp_mux: RTL
=================

AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 Parameter DW, default 32, HRDATA width per slave and to the master.
REQ-002 Parameter NSLV, default 4, number of decoded slaves; equals the decoder's slave_sel width.
REQ-003 HCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 HRESETn  input  1  reset; synchronous and active-low.
REQ-005 slave_sel  input  NSLV  one-hot address-phase select from the address decoder; all-zero means unmapped.
REQ-006 HTRANS  input  2  master address-phase transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-007 HRDATA_S  input  NSLV*DW  packed slave read data; slave i occupies bits [i*DW +: DW].
REQ-008 HREADYOUT_S  input  NSLV  per-slave ready.
REQ-009 HRESP_S  input  NSLV  per-slave response (0=OKAY, 1=ERROR).
REQ-010 HRDATA  output  DW  read data to the master.
REQ-011 HREADY  output  1  combined ready to the master, also fed back to every slave.
REQ-012 HRESP  output  1  combined response to the master.

Function
REQ-013 Data-phase select register dsel (NSLV+1 bits, bit NSLV = default slave) SHALL load only on an HCLK edge where HREADY=1.
REQ-014 Load value: slave_sel when it has exactly one bit set; else bit NSLV when HTRANS is NONSEQ or SEQ; else all-zero (no slave).
REQ-015 slave_sel with more than one bit set SHALL be treated as unmapped (REQ-014 default-slave rule).
REQ-016 When dsel selects slave i: HRDATA = HRDATA_S[i], HREADY = HREADYOUT_S[i], HRESP = HRESP_S[i], combinationally, zero added latency.
REQ-017 When dsel is all-zero: HRDATA=0, HREADY=1, HRESP=0 (OKAY, zero wait).
REQ-018 While HREADY=0, dsel SHALL hold regardless of slave_sel/HTRANS changes.
REQ-019 Default slave FSM states: IDLE, ERR1, ERR2.
REQ-020 IDLE -> ERR1 on an HREADY=1 edge loading dsel bit NSLV; otherwise stay in IDLE.
REQ-021 ERR1: HREADY=0, HRESP=1, HRDATA=0; always -> ERR2 next cycle.
REQ-022 ERR2: HREADY=1, HRESP=1, HRDATA=0; the address phase present in ERR2 is sampled per REQ-013; -> ERR1 if it is again unmapped active, else -> IDLE.
REQ-023 Back-to-back unmapped NONSEQ transfers SHALL produce repeating ERR1/ERR2 pairs with no IDLE cycle between.
REQ-024 Master changing HTRANS to IDLE during ERR1 SHALL be legal; the value sampled at the end of ERR2 determines the next state.
REQ-025 BUSY or IDLE to unmapped address SHALL never enter ERR1.

Reset
REQ-026 On an HCLK edge with HRESETn=0: dsel=all-zero, FSM=IDLE; consequently HREADY=1, HRESP=0, HRDATA=0 from the following cycle.
REQ-027 Reset asserted mid-ERR1/ERR2 or mid-stalled slave transfer SHALL abort it; no residual ERROR response after release.
REQ-028 No output SHALL depend on HRESETn combinationally.

Structure
REQ-029 Shared package ahb_pkg SHALL hold HTRANS encodings, HRESP codes, default-slave FSM state enum, default DW/NSLV.
REQ-030 Default slave SHALL be a sub-module ahb_default_slave (inputs HCLK, HRESETn, sel, HREADY; outputs HREADYOUT, HRESP); the mux instantiates it as slave index NSLV.

Verification
REQ-031 NONSEQ to slave 2 (slave_sel=0100), slave 2 HRDATA=0xA5A5_0002, HREADYOUT=1 -> next cycle HRDATA=0xA5A5_0002, HREADY=1, HRESP=0.
REQ-032 Slave 1 selected, HREADYOUT_S[1] low 3 cycles while slave_sel toggles to 0001 -> HREADY=0 for 3 cycles, dsel stays slave 1, then switches to slave 0 after the completing cycle.
REQ-033 NONSEQ with slave_sel=0000 -> cycle+1 HREADY=0/HRESP=1, cycle+2 HREADY=1/HRESP=1, cycle+3 HREADY=1/HRESP=0 if followed by IDLE.
REQ-034 Two consecutive unmapped NONSEQ, then slave_sel=1000 -> ERR1,ERR2,ERR1,ERR2, then slave 3 data phase with HRESP=0.
REQ-035 slave_sel=0110 with NONSEQ -> ERROR sequence as in REQ-033; slave_sel=0000 with IDLE -> HREADY=1, HRESP=0, no wait.
REQ-036 HRESETn=0 for one edge during ERR1 -> next cycle HREADY=1, HRESP=0, HRDATA=0, FSM IDLE.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/response encodings, default-slave states
// and the default mux geometry.
package ahb_pkg;

  localparam int DW_DEFAULT   = 32;
  localparam int NSLV_DEFAULT = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // NONSEQ and SEQ are the only transfer types that demand a response.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: answers every active transfer with
// the two-cycle AHB ERROR response, and OKAY/zero-wait otherwise.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic sel,
  input  logic HREADY,
  output logic HREADYOUT,
  output logic HRESP
);

  ds_state_t state_reg, state_next;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_reg <= DS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    case (state_reg)
      DS_IDLE: begin
        if (HREADY && sel) state_next = DS_ERR1;
      end
      DS_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = HRESP_ERROR;
        state_next = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP      = HRESP_ERROR;
        // The address phase overlapping ERR2 decides whether another pair follows.
        state_next = (HREADY && sel) ? DS_ERR1 : DS_IDLE;
      end
      default: state_next = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB slave-to-master response multiplexer with data-phase select register
// and an embedded default slave occupying select index NSLV.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NSLV = NSLV_DEFAULT
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NSLV-1:0]    slave_sel,
  input  logic [1:0]         HTRANS,
  input  logic [NSLV*DW-1:0] HRDATA_S,
  input  logic [NSLV-1:0]    HREADYOUT_S,
  input  logic [NSLV-1:0]    HRESP_S,
  output logic [DW-1:0]      HRDATA,
  output logic               HREADY,
  output logic               HRESP
);

  logic [NSLV:0]   dsel_reg, dsel_next;
  logic            sel_onehot;
  logic            unmapped_active;
  logic            def_readyout, def_resp;
  logic [NSLV:0]   ready_all, resp_all;
  logic [DW-1:0]   data_masked [NSLV];

  // Multi-hot selects are decoder faults and are routed to the default slave.
  assign sel_onehot      = (|slave_sel) && ((slave_sel & (slave_sel - NSLV'(1))) == '0);
  assign unmapped_active = !sel_onehot && htrans_active(HTRANS);

  always_comb begin
    dsel_next = '0;
    if (sel_onehot) begin
      dsel_next = {1'b0, slave_sel};
    end else if (unmapped_active) begin
      dsel_next[NSLV] = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dsel_reg <= '0;
    end else if (HREADY) begin
      dsel_reg <= dsel_next;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sel       (unmapped_active),
    .HREADY    (HREADY),
    .HREADYOUT (def_readyout),
    .HRESP     (def_resp)
  );

  assign ready_all = {def_readyout, HREADYOUT_S};
  assign resp_all  = {def_resp, HRESP_S};

  generate
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_data_mask
      assign data_masked[gi] = HRDATA_S[gi*DW +: DW] & {DW{dsel_reg[gi]}};
    end
  endgenerate

  // dsel is one-hot or zero, so an AND-OR tree is a full mux; the default
  // slave always returns zero data and needs no term.
  always_comb begin
    HRDATA = '0;
    for (int i = 0; i < NSLV; i++) begin
      HRDATA = HRDATA | data_masked[i];
    end
    HREADY = (dsel_reg == '0) || (|(dsel_reg & ready_all));
    HRESP  = |(dsel_reg & resp_all);
  end

endmodule
